// File: rtl/io_buffer.sv
// Memory-mapped I/O buffer: byte-maskable output registers written by the store path,
// plus synchronized and debounced switch/button inputs presented as 32-bit read buffers.
`timescale 1ns/1ps

module io_debounce #(
  parameter int WIDTH  = 18,
  parameter int CYCLES = 16,
  parameter bit INVERT = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] stable
);
  localparam int CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CYCLES - 1);
  localparam logic [WIDTH-1:0] INV_MASK = INVERT ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

  logic [WIDTH-1:0] sync1_reg;
  logic [WIDTH-1:0] sync2_reg;
  logic [WIDTH-1:0] hist_reg;
  logic [WIDTH-1:0] stable_reg;
  logic [CNT_W-1:0] cnt_reg;

  // One counter covers the whole vector: any bit toggling restarts it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg  <= '0;
      sync2_reg  <= '0;
      hist_reg   <= '0;
      stable_reg <= '0;
      cnt_reg    <= '0;
    end else begin
      sync1_reg <= raw ^ INV_MASK;
      sync2_reg <= sync1_reg;
      if (sync2_reg != hist_reg) begin
        hist_reg <= sync2_reg;
        cnt_reg  <= '0;
      end else if (cnt_reg < CNT_MAX) begin
        cnt_reg <= cnt_reg + 1'b1;
      end else begin
        stable_reg <= hist_reg;
      end
    end
  end

  assign stable = stable_reg;
endmodule

module io_buffer #(
  parameter int SW_WIDTH        = 18,
  parameter int BTN_WIDTH       = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_st_en,
  input  logic [31:0]          i_st_addr,
  input  logic [31:0]          i_st_data,
  input  logic [3:0]           i_st_bmask,
  input  logic                 f_io_valid,
  input  logic [SW_WIDTH-1:0]  i_io_sw,
  input  logic [BTN_WIDTH-1:0] i_io_btn,
  output logic [31:0]          b_io_ledr,
  output logic [31:0]          b_io_ledg,
  output logic [31:0]          b_io_hexl,
  output logic [31:0]          b_io_hexh,
  output logic [31:0]          b_io_lcd,
  output logic [31:0]          b_io_sw,
  output logic [31:0]          b_io_btn
);
  localparam int NUM_REGS = 5;

  logic                          st_hit;
  logic [3:0]                    st_sel;
  logic [NUM_REGS-1:0][3:0]      lane_we;
  logic [NUM_REGS-1:0][31:0]     regs_reg;
  logic [SW_WIDTH-1:0]           sw_db;
  logic [BTN_WIDTH-1:0]          btn_db;
  logic                          unused_addr_bits;

  // Address bits [11:0] alias within each 4 KB register window.
  assign unused_addr_bits = ^i_st_addr[11:0];
  assign st_hit = i_st_en && f_io_valid && (i_st_addr[31:16] == 16'h1000);
  assign st_sel = i_st_addr[15:12];

  genvar gi, gj;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      for (gj = 0; gj < 4; gj++) begin : g_lane
        assign lane_we[gi][gj] = st_hit && (st_sel == 4'(gi)) && i_st_bmask[gj];
      end
    end
  endgenerate

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      regs_reg <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        for (int k = 0; k < 4; k++) begin
          if (lane_we[r][k]) regs_reg[r][8*k +: 8] <= i_st_data[8*k +: 8];
        end
      end
    end
  end

  assign b_io_ledr = regs_reg[0];
  assign b_io_ledg = regs_reg[1];
  assign b_io_hexl = regs_reg[2];
  assign b_io_hexh = regs_reg[3];
  assign b_io_lcd  = regs_reg[4];

  io_debounce #(
    .WIDTH  (SW_WIDTH),
    .CYCLES (DEBOUNCE_CYCLES),
    .INVERT (1'b0)
  ) u_sw_db (
    .clk    (i_clk),
    .rst    (i_reset),
    .raw    (i_io_sw),
    .stable (sw_db)
  );

  io_debounce #(
    .WIDTH  (BTN_WIDTH),
    .CYCLES (DEBOUNCE_CYCLES),
    .INVERT (BTN_ACTIVE_LOW)
  ) u_btn_db (
    .clk    (i_clk),
    .rst    (i_reset),
    .raw    (i_io_btn),
    .stable (btn_db)
  );

  assign b_io_sw  = 32'(sw_db);
  assign b_io_btn = 32'(btn_db);
endmodule

// File: tb/tb_io_buffer.sv
// Self-checking bench for io_buffer: directed cases with literal expectations, then
// randomized stores and input toggling checked every cycle against a window-based model.
`timescale 1ns/1ps

module tb_io_buffer;
  localparam int SW_W = 18;
  localparam int BTN_W = 4;
  localparam int DB = 16;
  localparam bit BTN_AL = 1'b1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             st_en = 1'b0;
  logic [31:0]      st_addr = '0;
  logic [31:0]      st_data = '0;
  logic [3:0]       st_bmask = '0;
  logic             io_valid = 1'b0;
  logic [SW_W-1:0]  sw = '0;
  logic [BTN_W-1:0] btn = '1;
  logic [31:0] ledr, ledg, hexl, hexh, lcd, sw_out, btn_out;

  int total = 0;
  int bad = 0;

  io_buffer #(
    .SW_WIDTH(SW_W), .BTN_WIDTH(BTN_W), .DEBOUNCE_CYCLES(DB), .BTN_ACTIVE_LOW(BTN_AL)
  ) dut (
    .i_clk(clk), .i_reset(rst), .i_st_en(st_en), .i_st_addr(st_addr),
    .i_st_data(st_data), .i_st_bmask(st_bmask), .f_io_valid(io_valid),
    .i_io_sw(sw), .i_io_btn(btn),
    .b_io_ledr(ledr), .b_io_ledg(ledg), .b_io_hexl(hexl), .b_io_hexh(hexh),
    .b_io_lcd(lcd), .b_io_sw(sw_out), .b_io_btn(btn_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: registers as a plain word array; each debounced output is the
  // oldest sample of a (DB+1)-long window of equal samples delayed two edges.
  logic [31:0]      m_reg [5];
  logic [SW_W-1:0]  sw_q  [$];
  logic [BTN_W-1:0] btn_q [$];
  logic [31:0]      m_sw, m_btn;

  task automatic model_reset();
    for (int r = 0; r < 5; r++) m_reg[r] = '0;
    sw_q = '{};  repeat (3) sw_q.push_back('0);
    btn_q = '{}; repeat (3) btn_q.push_back('0);
    m_sw = '0;
    m_btn = '0;
  endtask

  task automatic model_edge();
    logic [BTN_W-1:0] b;
    bit eq;
    if (st_en && io_valid && st_addr[31:16] == 16'h1000 && st_addr[15:12] < 4'd5)
      for (int k = 0; k < 4; k++)
        if (st_bmask[k]) m_reg[st_addr[15:12]][8*k +: 8] = st_data[8*k +: 8];
    sw_q.push_back(sw);
    if (sw_q.size() > DB + 3) void'(sw_q.pop_front());
    if (sw_q.size() == DB + 3) begin
      eq = 1'b1;
      for (int i = 1; i <= DB; i++) if (sw_q[i] != sw_q[0]) eq = 1'b0;
      if (eq) m_sw = 32'(sw_q[0]);
    end
    b = BTN_AL ? ~btn : btn;
    btn_q.push_back(b);
    if (btn_q.size() > DB + 3) void'(btn_q.pop_front());
    if (btn_q.size() == DB + 3) begin
      eq = 1'b1;
      for (int i = 1; i <= DB; i++) if (btn_q[i] != btn_q[0]) eq = 1'b0;
      if (eq) m_btn = 32'(btn_q[0]);
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_edge();
    end
  end

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      chk("cyc_ledr", ledr, m_reg[0]);
      chk("cyc_ledg", ledg, m_reg[1]);
      chk("cyc_hexl", hexl, m_reg[2]);
      chk("cyc_hexh", hexh, m_reg[3]);
      chk("cyc_lcd",  lcd,  m_reg[4]);
      chk("cyc_sw",   sw_out,  m_sw);
      chk("cyc_btn",  btn_out, m_btn);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                       input logic v);
    st_en = 1'b1; st_addr = a; st_data = d; st_bmask = m; io_valid = v;
    tick();
    st_en = 1'b0; io_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sw_hold, btn_hold;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("rst_ledr", ledr, 32'h0);
    chk("rst_lcd",  lcd,  32'h0);
    chk("rst_sw",   sw_out, 32'h0);
    chk("rst_btn",  btn_out, 32'h0);
    repeat (20) tick();

    store(32'h1000_0004, 32'hDEADBEEF, 4'b1111, 1'b1);
    chk("st_ledr_full", ledr, 32'hDEADBEEF);
    chk("st_ledg_clean", ledg, 32'h0);
    store(32'h1000_0000, 32'h0000AB00, 4'b0010, 1'b1);
    chk("st_ledr_byte1", ledr, 32'hDEADABEF);
    store(32'h1000_5000, 32'hFFFFFFFF, 4'b1111, 1'b1);
    store(32'h1001_0000, 32'hFFFFFFFF, 4'b1111, 1'b1);
    chk("st_ignored_ledr", ledr, 32'hDEADABEF);
    chk("st_ignored_lcd", lcd, 32'h0);
    chk("st_ignored_sw", sw_out, 32'h0);
    store(32'h1000_2ABC, 32'h7F3F067F, 4'b1111, 1'b1);
    chk("st_hexl", hexl, 32'h7F3F067F);
    store(32'h1000_2000, 32'h11111111, 4'b1111, 1'b0);
    chk("st_novalid_hexl", hexl, 32'h7F3F067F);
    store(32'h1000_3000, 32'hAA00BB00, 4'b0000, 1'b1);
    chk("st_nomask_hexh", hexh, 32'h0);

    sw = 18'h1;
    repeat (10) tick();
    sw = '0;
    repeat (30) tick();
    chk("sw_glitch", sw_out, 32'h0);

    sw = 18'h2A5A5;
    repeat (18) tick();
    chk("sw_edge18", sw_out, 32'h0);
    tick();
    chk("sw_edge19", sw_out, 32'h0002A5A5);

    btn = 4'b1110;
    repeat (18) tick();
    chk("btn_press18", btn_out, 32'h0);
    tick();
    chk("btn_press19", btn_out, 32'h1);
    btn = 4'b1111;
    repeat (18) tick();
    chk("btn_rel18", btn_out, 32'h1);
    tick();
    chk("btn_rel19", btn_out, 32'h0);

    store(32'h1000_4000, 32'h12345678, 4'b1111, 1'b1);
    chk("st_lcd", lcd, 32'h12345678);
    sw = 18'h3;
    repeat (5) tick();
    #2 rst = 1'b1;
    #1;
    chk("arst_ledr", ledr, 32'h0);
    chk("arst_hexl", hexl, 32'h0);
    chk("arst_lcd",  lcd,  32'h0);
    chk("arst_sw",   sw_out, 32'h0);
    chk("arst_btn",  btn_out, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (18) tick();
    chk("post_rst_sw18", sw_out, 32'h0);
    tick();
    chk("post_rst_sw19", sw_out, 32'h3);

    sw_hold = 0;
    btn_hold = 0;
    for (int c = 0; c < 3000; c++) begin
      if (sw_hold == 0) begin
        sw = SW_W'($urandom);
        sw_hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, DB) : $urandom_range(DB, 40);
      end
      if (btn_hold == 0) begin
        btn = BTN_W'($urandom);
        btn_hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, DB) : $urandom_range(DB, 40);
      end
      sw_hold--;
      btn_hold--;
      st_en    = ($urandom_range(0, 1) == 1);
      io_valid = ($urandom_range(0, 7) != 0);
      st_addr  = {(($urandom_range(0, 7) == 0) ? 16'h1001 : 16'h1000),
                  4'($urandom_range(0, 7)), 12'($urandom)};
      st_data  = $urandom;
      st_bmask = 4'($urandom);
      tick();
    end
    st_en = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/io_buffer.md
Name: io_buffer

Overview:
- Holds the memory-mapped I/O state read by the load-data mux and routed to board outputs.
- Output peripherals: byte-maskable store registers for LEDR, LEDG, HEXL, HEXH and LCD, written by the LSU store path.
- Input peripherals: raw switches and buttons pass through a 2-flop synchronizer and a debouncer before being presented as 32-bit read buffers.
- Sits between the LSU store path / board pins and the load mux plus output pin routing.

Parameters:
- SW_WIDTH, 18, number of raw switch inputs (1..32).
- BTN_WIDTH, 4, number of raw button inputs (1..32).
- DEBOUNCE_CYCLES, 16, consecutive stable synchronized cycles required before an input change is accepted (>=1).
- BTN_ACTIVE_LOW, 1, 1 = raw buttons are inverted before synchronization so that a pressed button reads 1.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  asynchronous reset, active-high.
- i_st_en  in  1  store request this cycle.
- i_st_addr  in  32  store byte address.
- i_st_data  in  32  store data, already lane-aligned.
- i_st_bmask  in  4  byte enables; bit k = byte lane k.
- f_io_valid  in  1  address decode flag: i_st_addr lies in the I/O region.
- i_io_sw  in  SW_WIDTH  raw switch pins, asynchronous.
- i_io_btn  in  BTN_WIDTH  raw button pins, asynchronous.
- b_io_ledr  out  32  red LED buffer.
- b_io_ledg  out  32  green LED buffer.
- b_io_hexl  out  32  HEX3-0 buffer; 7-bit digits in bits [6:0] [14:8] [22:16] [30:24].
- b_io_hexh  out  32  HEX7-4 buffer, same packing as b_io_hexl.
- b_io_lcd  out  32  LCD buffer.
- b_io_sw  out  32  debounced switches, zero-extended.
- b_io_btn  out  32  debounced buttons (1 = pressed), zero-extended.

Behaviour:
- Reset (async, i_reset=1): every output buffer, synchronizer flop, debounce history register and counter is cleared to 0, taking effect immediately without waiting for a clock edge.
  - Inversion is applied before the synchronizer, so cleared button state means released.
  - Reset asserted mid-debounce discards the pending change.
- Store decode: a write occurs on an i_clk rising edge only when all of the following hold:
  - i_st_en=1, f_io_valid=1 and i_st_addr[31:16]==16'h1000;
  - i_st_addr[15:12] selects the target: 0 LEDR, 1 LEDG, 2 HEXL, 3 HEXH, 4 LCD;
  - values 5..F of i_st_addr[15:12] are ignored with no side effect;
  - address bits [11:0] are ignored, so every address in a 4 KB window aliases the same register.
- Byte masking: for each k in 0..3, byte k of the selected register takes i_st_data[8k+7:8k] only if i_st_bmask[k]=1. Unmasked bytes hold their value; i_st_bmask=0 writes nothing.
- HEX bits 7, 15, 23 and 31 are stored exactly as written.
- Latency: the new register value is visible on the b_io_* output in the cycle after the store edge, so a load issued in the next cycle returns the new value.
- Stores to 0x1001_xxxx (switch region) are silently dropped; b_io_sw and b_io_btn are never CPU-writable.
- Switch and button paths are identical and independent; each has its own synchronizer, history register and counter. Per path:
  - sync1 <= raw (inverted for buttons when BTN_ACTIVE_LOW=1); sync2 <= sync1.
  - If sync2 != hist: hist <= sync2 and cnt <= 0.
  - Else if cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - Else (cnt saturated at DEBOUNCE_CYCLES-1): output <= hist.
  - Counter width is clog2(DEBOUNCE_CYCLES), minimum 1 bit.
- Debounce latency: a raw change held stable appears on the output DEBOUNCE_CYCLES+3 rising edges after it is applied before edge 1. That is 19 edges at the default; 4 edges with DEBOUNCE_CYCLES=1.
- Any synchronized toggle restarts the count. A glitch shorter than DEBOUNCE_CYCLES stable cycles never reaches the output.
- The counter saturates and does not wrap.
- Multiple bits changing in different cycles restart the shared per-path counter each time; the whole vector is accepted together once stable.
- Upper bits [31:SW_WIDTH] and [31:BTN_WIDTH] are always 0.

Test Plan:
- Reset, then store 0x1000_0004 data 0xDEADBEEF bmask 4'b1111 -> next cycle b_io_ledr=0xDEADBEEF; all other outputs remain 0.
- Then store 0x1000_0000 data 0x0000AB00 bmask 4'b0010 -> b_io_ledr=0xDEADABEF. Store to 0x1000_5000 or 0x1001_0000 -> no register changes.
- Store 0x1000_2000 data 0x7F3F067F bmask 4'b1111 -> b_io_hexl=0x7F3F067F. f_io_valid=0 with the same request -> no change.
- i_io_sw 0 -> 18'h2A5A5 held -> b_io_sw=0x0002A5A5 exactly at edge 19. A 10-cycle pulse to 18'h1 -> b_io_sw stays 0.
- BTN_ACTIVE_LOW=1, i_io_btn=4'b1111 after reset, drive 4'b1110 stable -> b_io_btn=0x00000001 after 19 edges. Release -> 0 after 19 edges.
- Assert i_reset asynchronously mid-debounce and with LCD=0x12345678 -> all outputs 0 before the next clock edge. After release, the pending input change takes the full 19 edges from scratch.
